// File: rtl/vga_sync_decoder_if.sv
// Signal bundle between a TinyVGA PMOD source and the sync decoder.
// The master side drives the video byte and probe coordinates; the slave
// side (the decoder) returns the recovered position, colour and status.
interface vga_sync_decoder_if;
  logic [7:0] vga_in;
  logic [9:0] probe_x;
  logic [9:0] probe_y;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       display_on;
  logic [1:0] R;
  logic [1:0] G;
  logic [1:0] B;
  logic       locked;
  logic       line_err;
  logic       frame_err;
  logic [7:0] frame_count;
  logic [5:0] probe_rgb;
  logic       probe_valid;

  modport master (
    output vga_in, probe_x, probe_y,
    input  hpos, vpos, display_on, R, G, B, locked, line_err, frame_err,
           frame_count, probe_rgb, probe_valid
  );

  modport slave (
    input  vga_in, probe_x, probe_y,
    output hpos, vpos, display_on, R, G, B, locked, line_err, frame_err,
           frame_count, probe_rgb, probe_valid
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// TinyVGA PMOD receiver: recovers pixel position and 2-bit RGB from the
// sync/colour pins, tracks timing lock, flags misplaced sync edges and
// captures one programmable pixel per frame.
module vga_sync_decoder #(
  parameter int H_DISPLAY       = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_DISPLAY       = 480,
  parameter int V_BOTTOM        = 10,
  parameter int V_SYNC          = 2,
  parameter int V_TOP           = 33,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic             clk,
  input  logic             reset,
  vga_sync_decoder_if.slave bus
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  HS_POS   = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0]  VS_POS   = 10'(V_DISPLAY + V_BOTTOM);
  localparam logic [9:0]  H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0]  V_VIS    = 10'(V_DISPLAY);
  localparam logic [11:0] WD_LIMIT = 12'(2 * H_TOTAL);

  // Pin level of a deasserted sync; XOR with it turns a pin into "asserted".
  localparam logic       SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);
  localparam logic [7:0] IN_IDLE   = {SYNC_IDLE, 3'b000, SYNC_IDLE, 3'b000};

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    HLOCK  = 2'd1,
    VSYNC1 = 2'd2,
    LOCKED = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [7:0]  in_q;
  logic        hs_prev, vs_prev;
  logic        hs_now, vs_now, hs_edge, vs_edge;
  logic [11:0] wd, wd_next;
  logic        wd_expired;
  logic [9:0]  h_free, v_free, h_next, v_next;
  logic        line_bad, frame_bad, line_err_d, frame_err_d;
  logic        in_window, probe_hit, count_frame;
  logic [1:0]  r_pix, g_pix, b_pix;

  // Input register plus previous asserted-sync levels for edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_q    <= IN_IDLE;
      hs_prev <= 1'b0;
      vs_prev <= 1'b0;
    end else begin
      in_q    <= bus.vga_in;
      hs_prev <= hs_now;
      vs_prev <= vs_now;
    end
  end

  // Decode the registered sample: free-running position, sync forcing, errors.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    hs_now  = in_q[7] ^ SYNC_IDLE;
    vs_now  = in_q[3] ^ SYNC_IDLE;
    hs_edge = hs_now & ~hs_prev;
    vs_edge = vs_now & ~vs_prev;
    r_pix   = {in_q[0], in_q[4]};
    g_pix   = {in_q[1], in_q[5]};
    b_pix   = {in_q[2], in_q[6]};

    h_free = (bus.hpos == H_LAST) ? 10'd0 : bus.hpos + 10'd1;
    v_free = bus.vpos;
    if (bus.hpos == H_LAST) v_free = (bus.vpos == V_LAST) ? 10'd0 : bus.vpos + 10'd1;

    h_next    = h_free;
    v_next    = v_free;
    line_bad  = 1'b0;
    frame_bad = 1'b0;
    // hsync is applied first so that a coincident vsync check and force win.
    if (hs_edge) begin
      line_bad = (h_free != HS_POS);
      h_next   = HS_POS;
    end
    if (vs_edge) begin
      frame_bad = (h_next != 10'd0) || (v_next != VS_POS);
      h_next    = 10'd0;
      v_next    = VS_POS;
    end

    line_err_d  = line_bad && (state != SEARCH);
    frame_err_d = frame_bad && ((state == VSYNC1) || (state == LOCKED));

    // Watchdog saturates at its limit so it keeps holding the FSM in SEARCH.
    wd_next = '0;
    if (!hs_edge) wd_next = (wd == WD_LIMIT) ? wd : wd + 12'd1;
    wd_expired = (wd_next == WD_LIMIT);

    in_window = (state == LOCKED) && (h_next < H_VIS) && (v_next < V_VIS);
    probe_hit = in_window && (bus.probe_x < H_VIS) && (bus.probe_y < V_VIS) &&
                (h_next == bus.probe_x) && (v_next == bus.probe_y);
  end

  // Lock FSM next state.
  always_comb begin
    state_next = state;
    unique case (state)
      SEARCH: if (hs_edge) state_next = HLOCK;
      HLOCK:  if (vs_edge) state_next = VSYNC1;
      VSYNC1, LOCKED: begin
        if (line_err_d || frame_err_d) state_next = HLOCK;
        else if (vs_edge)              state_next = LOCKED;
      end
      default: state_next = SEARCH;
    endcase
    if (wd_expired) state_next = SEARCH;
    count_frame = vs_edge && (state_next == LOCKED);
  end

  // Lock FSM state and hsync watchdog registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SEARCH;
      wd    <= '0;
    end else begin
      state <= state_next;
      wd    <= wd_next;
    end
  end

  // Output register: every output describes the same in_q sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.hpos        <= '0;
      bus.vpos        <= '0;
      bus.display_on  <= 1'b0;
      bus.R           <= '0;
      bus.G           <= '0;
      bus.B           <= '0;
      bus.locked      <= 1'b0;
      bus.line_err    <= 1'b0;
      bus.frame_err   <= 1'b0;
      bus.frame_count <= '0;
      bus.probe_rgb   <= '0;
      bus.probe_valid <= 1'b0;
    end else begin
      bus.hpos        <= h_next;
      bus.vpos        <= v_next;
      bus.display_on  <= in_window;
      bus.R           <= in_window ? r_pix : 2'b00;
      bus.G           <= in_window ? g_pix : 2'b00;
      bus.B           <= in_window ? b_pix : 2'b00;
      // Lags the state register by one clock, matching display_on gating.
      bus.locked      <= (state == LOCKED);
      bus.line_err    <= line_err_d;
      bus.frame_err   <= frame_err_d;
      bus.probe_valid <= probe_hit;
      if (count_frame) bus.frame_count <= bus.frame_count + 8'd1;
      if (probe_hit)   bus.probe_rgb   <= {r_pix, g_pix, b_pix};
    end
  end
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Self-checking bench for vga_sync_decoder using a scaled-down video timing
// so several whole frames fit in a short run. A behavioural model follows the
// decoder rules on each sample and every output is compared each clock.
module tb_vga_sync_decoder;
  localparam int HD = 16, HF = 2, HSW = 4, HB = 3;
  localparam int VD = 12, VB = 2, VSW = 2, VTP = 3;
  localparam int HT  = HD + HF + HSW + HB;   // 25
  localparam int VT  = VD + VB + VSW + VTP;  // 19
  localparam int HSP = HD + HF;              // 18
  localparam int VSP = VD + VB;              // 14
  localparam int WDL = 2 * HT;               // 50
  localparam int WX = 8, WY = 6;             // white probe pixel
  localparam logic [7:0] IDLE = 8'h88;       // both syncs deasserted (active low)

  logic clk = 1'b0;
  logic reset = 1'b0;
  bit   chk_en = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  vga_sync_decoder_if bus ();

  vga_sync_decoder #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_DISPLAY(VD), .V_BOTTOM(VB), .V_SYNC(VSW), .V_TOP(VTP),
    .SYNC_ACTIVE_LOW(1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef enum {M_SEARCH, M_HLOCK, M_VSYNC1, M_LOCKED} mstate_t;
  mstate_t    m_st;
  logic [7:0] m_in;
  bit         m_hs, m_vs;
  int         m_h, m_v, m_since;
  int         e_hpos, e_vpos, e_fc;
  bit         e_disp, e_locked, e_lerr, e_ferr, e_pv;
  logic [1:0] e_r, e_g, e_b;
  logic [5:0] e_prgb;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_st = M_SEARCH; m_in = IDLE; m_hs = 0; m_vs = 0;
      m_h = 0; m_v = 0; m_since = 0;
      e_hpos = 0; e_vpos = 0; e_fc = 0; e_disp = 0; e_locked = 0;
      e_lerr = 0; e_ferr = 0; e_pv = 0; e_r = 0; e_g = 0; e_b = 0; e_prgb = 0;
    end else begin
      logic [7:0] s;
      bit hs, vs, hedge, vedge, was_locked;
      mstate_t nst;
      s = m_in;
      m_in = bus.vga_in;
      hs = (s[7] == 1'b0);
      vs = (s[3] == 1'b0);
      hedge = hs && !m_hs;
      vedge = vs && !m_vs;
      m_hs = hs;
      m_vs = vs;
      m_h = m_h + 1;
      if (m_h == HT) begin
        m_h = 0;
        m_v = (m_v + 1) % VT;
      end
      e_lerr = 0;
      e_ferr = 0;
      if (hedge) begin
        if (m_h != HSP && m_st != M_SEARCH) e_lerr = 1;
        m_h = HSP;
      end
      if (vedge) begin
        if ((m_h != 0 || m_v != VSP) && (m_st == M_VSYNC1 || m_st == M_LOCKED)) e_ferr = 1;
        m_h = 0;
        m_v = VSP;
      end
      was_locked = (m_st == M_LOCKED);
      m_since = hedge ? 0 : m_since + 1;
      nst = m_st;
      if (m_st == M_SEARCH) begin
        if (hedge) nst = M_HLOCK;
      end else if (m_st == M_HLOCK) begin
        if (vedge) nst = M_VSYNC1;
      end else begin
        if (e_lerr || e_ferr) nst = M_HLOCK;
        else if (vedge)       nst = M_LOCKED;
      end
      if (m_since >= WDL) nst = M_SEARCH;
      if (vedge && nst == M_LOCKED) e_fc = (e_fc + 1) % 256;
      m_st = nst;
      e_hpos = m_h;
      e_vpos = m_v;
      e_locked = was_locked;
      e_disp = was_locked && (m_h < HD) && (m_v < VD);
      e_r = e_disp ? {s[0], s[4]} : 2'b00;
      e_g = e_disp ? {s[1], s[5]} : 2'b00;
      e_b = e_disp ? {s[2], s[6]} : 2'b00;
      e_pv = e_disp && (m_h == int'(bus.probe_x)) && (m_v == int'(bus.probe_y));
      if (e_pv) e_prgb = {e_r, e_g, e_b};
    end
  end

  // Per-clock comparison on the falling edge plus pulse bookkeeping.
  int cnt_pv = 0, cnt_le = 0, cnt_fe = 0;
  int ferr_h = -1, ferr_v = -1;
  always @(negedge clk) begin
    if (chk_en) begin
      check("hpos", bus.hpos, e_hpos);
      check("vpos", bus.vpos, e_vpos);
      check("display_on", bus.display_on, e_disp);
      check("rgb", {bus.R, bus.G, bus.B}, {e_r, e_g, e_b});
      check("locked", bus.locked, e_locked);
      check("line_err", bus.line_err, e_lerr);
      check("frame_err", bus.frame_err, e_ferr);
      check("frame_count", bus.frame_count, e_fc[7:0]);
      check("probe_valid", bus.probe_valid, e_pv);
      check("probe_rgb", bus.probe_rgb, e_prgb);
      if (bus.probe_valid === 1'b1) cnt_pv++;
      if (bus.line_err === 1'b1) cnt_le++;
      if (bus.frame_err === 1'b1) begin
        cnt_fe++;
        ferr_h = int'(bus.hpos);
        ferr_v = int'(bus.vpos);
      end
    end
  end

  // ---------------- video generator ----------------
  // Colour is random everywhere (including blanking) unless white is set,
  // in which case only the probe pixel is lit.
  function automatic logic [7:0] pix(input int x, input int y, input bit white);
    logic hs_pin, vs_pin;
    logic [5:0] c;
    hs_pin = !(x >= HSP && x < HSP + HSW);
    vs_pin = !(y >= VSP && y < VSP + VSW);
    if (white) c = (x == WX && y == WY) ? 6'h3f : 6'h00;
    else       c = 6'($urandom);
    // c = {R1,R0,G1,G0,B1,B0}; pin byte = {hs,B0,G0,R0,vs,B1,G1,R1}
    return {hs_pin, c[0], c[2], c[4], vs_pin, c[1], c[3], c[5]};
  endfunction

  task automatic put(input logic [7:0] b);
    @(posedge clk);
    #1 bus.vga_in = b;
  endtask

  task automatic send_lines(input int y0, input int y1, input int long_y, input bit white);
    for (int y = y0; y <= y1; y++) begin
      int len;
      len = (y == long_y) ? HT + 1 : HT;
      for (int x = 0; x < len; x++) put(pix(x, y, white));
    end
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) send_lines(0, VT - 1, -1, 1'b0);
  endtask

  // ---------------- scenario ----------------
  initial begin
    int base, fc0;
    bus.vga_in  = IDLE;
    bus.probe_x = 10'(WX);
    bus.probe_y = 10'(WY);
    #2 reset = 1'b1;
    #20 chk_en = 1'b1;
    @(negedge clk);
    check("rst_hpos", bus.hpos, 0);
    check("rst_locked", bus.locked, 0);
    check("rst_frame_count", bus.frame_count, 0);
    reset = 1'b0;

    // Three clean frames: lock on the second vsync, count 1 then 2.
    frames(3);
    @(negedge clk);
    check("lock_after_3", bus.locked, 1);
    check("fc_after_3", bus.frame_count, 2);

    // White pixel at the probe point: exactly one capture of full white.
    base = cnt_pv;
    send_lines(0, VT - 1, -1, 1'b1);
    @(negedge clk);
    check("probe_hits", cnt_pv - base, 1);
    check("probe_white", bus.probe_rgb, 6'h3f);

    // Probe outside the display window never fires.
    bus.probe_x = 10'(HD + 4);
    bus.probe_y = 10'd1;
    base = cnt_pv;
    send_lines(0, VT - 1, -1, 1'b1);
    @(negedge clk);
    check("probe_outside", cnt_pv - base, 0);
    bus.probe_x = 10'($urandom_range(0, HD - 1));
    bus.probe_y = 10'($urandom_range(0, VD - 1));

    // One line stretched by a clock: line_err, unlock, relock two vsyncs on.
    fc0  = int'(bus.frame_count);
    base = cnt_le;
    send_lines(0, VT - 1, 5, 1'b0);
    @(negedge clk);
    check("stretch_line_err", cnt_le - base, 1);
    check("stretch_unlock", bus.locked, 0);
    check("stretch_fc_hold", bus.frame_count, fc0);
    frames(1);
    @(negedge clk);
    check("stretch_relock", bus.locked, 1);
    check("stretch_fc_next", bus.frame_count, (fc0 + 1) % 256);

    // Frame one line short: frame_err at the next vsync, position forced.
    base = cnt_fe;
    send_lines(0, VT - 2, -1, 1'b0);
    frames(1);
    @(negedge clk);
    check("short_frame_err", cnt_fe - base, 1);
    check("short_err_vpos", ferr_v, VSP);
    check("short_err_hpos", ferr_h, 0);
    check("short_unlock", bus.locked, 0);
    frames(2);
    @(negedge clk);
    check("short_relock", bus.locked, 1);

    // hsync held deasserted past the watchdog limit: back to SEARCH.
    for (int i = 0; i < WDL + 10; i++) put(IDLE | 8'($urandom_range(0, 7)) | {1'b0, 3'($urandom), 4'h0});
    @(negedge clk);
    check("wd_locked", bus.locked, 0);
    check("wd_display_on", bus.display_on, 0);
    check("wd_rgb", {bus.R, bus.G, bus.B}, 0);

    // Reset in the middle of a running frame.
    frames(1);
    send_lines(0, 7, -1, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("midrst_hpos", bus.hpos, 0);
    check("midrst_vpos", bus.vpos, 0);
    check("midrst_locked", bus.locked, 0);
    check("midrst_fc", bus.frame_count, 0);
    check("midrst_probe_rgb", bus.probe_rgb, 0);
    @(negedge clk);
    #2 reset = 1'b0;
    send_lines(8, VT - 1, -1, 1'b0);
    @(negedge clk);
    check("midrst_one_vsync", bus.locked, 0);
    frames(2);
    @(negedge clk);
    check("midrst_relock", bus.locked, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive side of the TinyVGA PMOD byte produced by our game tops; recovers pixel position, display window and 2-bit RGB from hsync/vsync/colour pins.
- Checks timing against 640x480 parameters and reports lock and errors.
- Samples one programmable pixel per frame for self-test and loopback benches.

Parameters:
H_DISPLAY, 640, active pixels per line
H_FRONT, 16, front porch clocks
H_SYNC, 96, hsync width clocks
H_BACK, 48, back porch clocks
V_DISPLAY, 480, active lines
V_BOTTOM, 10, bottom porch lines
V_SYNC, 2, vsync width lines
V_TOP, 33, top porch lines
SYNC_ACTIVE_LOW, 1, 1 = sync pins asserted low

Ports:
clk  in  1  pixel clock; single clock domain
reset  in  1  asynchronous, active-high reset
vga_in  in  8  PMOD byte {hsync,B[0],G[0],R[0],vsync,B[1],G[1],R[1]}
probe_x  in  10  probe column
probe_y  in  10  probe row
hpos  out  10  recovered column
vpos  out  10  recovered row
display_on  out  1  locked and hpos<H_DISPLAY and vpos<V_DISPLAY
R  out  2  recovered red {R[1],R[0]}, 0 outside display_on
G  out  2  recovered green
B  out  2  recovered blue
locked  out  1  timing lock
line_err  out  1  one-cycle pulse on bad hsync position
frame_err  out  1  one-cycle pulse on bad vsync position
frame_count  out  8  locked frames seen, wraps 255->0
probe_rgb  out  6  {R,G,B} captured at probe point
probe_valid  out  1  one-cycle pulse when probe_rgb updates

Behaviour:
- Derived constants:
  - H_TOTAL = sum of H_* (800)
  - V_TOTAL = sum of V_* (525)
  - HS_POS = H_DISPLAY+H_FRONT (656)
  - VS_POS = V_DISPLAY+V_BOTTOM (490)
- Asserted sync = pin XOR SYNC_ACTIVE_LOW.
- Latency: vga_in registered once, then all outputs registered.
  - Every output describes the vga_in sample taken 2 clocks earlier.
  - hpos/vpos/R/G/B stay mutually aligned.
- Counters: hpos increments each clock; at H_TOTAL-1 it wraps to 0 and vpos increments; vpos wraps V_TOTAL-1 -> 0.
- Sync edges: a sync edge is a deasserted->asserted transition of the registered sync.
- hsync edge:
  - Required position: hpos=HS_POS for that sample.
  - If the free-running count disagrees and state != SEARCH, pulse line_err.
  - Always force hpos=HS_POS, keeping vpos.
- vsync edge:
  - Required position: (hpos,vpos)=(0,VS_POS).
  - If the count disagrees and state is VSYNC1 or LOCKED, pulse frame_err.
  - Always force vpos=VS_POS, hpos=0.
- hsync watchdog: 12-bit counter cleared on every hsync edge; reaching 2*H_TOTAL sends the FSM to SEARCH.
- FSM:
  - SEARCH: after reset and on watchdog expiry. First hsync edge -> HLOCK.
  - HLOCK: first vsync edge -> VSYNC1. line_err stays in HLOCK.
  - VSYNC1: next vsync edge with no error since entry -> LOCKED. Any line_err/frame_err -> HLOCK.
  - LOCKED: line_err or frame_err -> HLOCK, locked deasserts the following clock. Watchdog -> SEARCH.
- locked = (state==LOCKED), registered.
- display_on, R, G, B are 0 whenever not locked.
- frame_count increments on each vsync edge while LOCKED, including the edge that enters LOCKED.
- Probe:
  - When locked and (hpos,vpos)==(probe_x,probe_y), capture {R,G,B} into probe_rgb and pulse probe_valid in the same cycle the matching pixel is output.
  - Probe coordinates outside the display window never match.
  - probe_x/probe_y are sampled continuously; a change takes effect next clock.
- Simultaneous hsync and vsync edges: process hsync first, then vsync. The vsync check and force win.
- Reset (async, any time):
  - hpos, vpos, R, G, B, display_on, locked, line_err, frame_err, frame_count, probe_rgb, probe_valid = 0.
  - Watchdog = 0; FSM = SEARCH; input register = deasserted syncs, zero colour.

Test Plan:
- Reset mid-frame while the stream runs → all outputs 0 within the reset cycle; after release, locked=0 until two clean vsync edges.
- Three clean 640x480 frames from the generator model → locked=1 two clocks after the second vsync sample; frame_count=1 then 2. Generator pixel (0,0) appears as hpos=0, vpos=0, display_on=1 two clocks later.
- Generator draws white only at (320,240); probe_x=320, probe_y=240 → exactly one probe_valid per frame with probe_rgb=6'b111111. Probe (700,10) → no probe_valid.
- One line stretched to 801 clocks → line_err pulse at the next hsync edge and locked drops. Relock (locked=1) two vsync edges later; frame_count holds meanwhile.
- hsync held deasserted for 1600 clocks → state SEARCH; locked, display_on, R/G/B all 0.
- Frame shortened to 524 lines while LOCKED → frame_err pulse at that vsync edge; vpos forced to 490, hpos to 0; locked=0 the next clock.
